// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo reservation station.
// Optional build macro RS_FWD_EN (see tomasulo_rs.sv).
package tomasulo_pkg;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 3;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_SLT = 3'd5;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qk;
    } rs_entry_t;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-first priority encoder: one-hot grant, binary index and any-request flag.
module rs_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    output logic [N-1:0]         o_onehot,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int IDX_W = $clog2(N);

    logic w_found;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_req[i] && !w_found) begin
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
                w_found     = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/tomasulo_rs.sv
// Reservation station: issue with CDB capture, CDB wakeup, in-order-by-index dispatch to one FU.
// Build macro RS_FWD_EN enables zero-cycle wakeup-to-dispatch forwarding from the CDB.
module tomasulo_rs #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = tomasulo_pkg::DATA_W,
    parameter int TAG_W    = tomasulo_pkg::TAG_W,
    parameter int OP_W     = tomasulo_pkg::OP_W,
    parameter int TAG_BASE = 1
) (
    input  logic                       clk1,
    input  logic                       rst,
    input  logic                       iss_valid,
    output logic                       iss_ready,
    input  logic [OP_W-1:0]            iss_op,
    input  logic [DATA_W-1:0]          iss_vj,
    input  logic [TAG_W-1:0]           iss_qj,
    input  logic [DATA_W-1:0]          iss_vk,
    input  logic [TAG_W-1:0]           iss_qk,
    output logic [TAG_W-1:0]           iss_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       fu_valid,
    input  logic                       fu_ready,
    output logic [OP_W-1:0]            fu_op,
    output logic [DATA_W-1:0]          fu_a,
    output logic [DATA_W-1:0]          fu_b,
    output logic [TAG_W-1:0]           fu_tag,
    output logic [$clog2(DEPTH+1)-1:0] busy_cnt
);

    import tomasulo_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    rs_entry_t          r_ent [DEPTH];
    logic [CNT_W-1:0]   r_busy_cnt;

    logic [DEPTH-1:0]   w_free;
    logic [DEPTH-1:0]   w_rdy;
    logic [DEPTH-1:0]   w_mj;
    logic [DEPTH-1:0]   w_mk;
    logic [DEPTH-1:0]   w_alloc_oh;
    logic [DEPTH-1:0]   w_sel_oh;
    logic [IDX_W-1:0]   w_alloc_idx;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_any_free;
    logic               w_any_rdy;
    logic               w_iss;
    logic               w_disp;
    logic               w_cdb_live;
    rs_entry_t          w_new;

    assign w_cdb_live = cdb_valid && (cdb_tag != TAG_NONE);

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_free[i] = !r_ent[i].busy;
            w_mj[i]   = w_cdb_live && (r_ent[i].qj == cdb_tag);
            w_mk[i]   = w_cdb_live && (r_ent[i].qk == cdb_tag);
`ifdef RS_FWD_EN
            w_rdy[i]  = r_ent[i].busy && ((r_ent[i].qj == TAG_NONE) || w_mj[i])
                                      && ((r_ent[i].qk == TAG_NONE) || w_mk[i]);
`else
            w_rdy[i]  = r_ent[i].busy && (r_ent[i].qj == TAG_NONE) && (r_ent[i].qk == TAG_NONE);
`endif
        end
    end

    rs_prio_enc #(.N(DEPTH)) u_free_enc (
        .i_req    (w_free),
        .o_onehot (w_alloc_oh),
        .o_idx    (w_alloc_idx),
        .o_any    (w_any_free)
    );

    rs_prio_enc #(.N(DEPTH)) u_rdy_enc (
        .i_req    (w_rdy),
        .o_onehot (w_sel_oh),
        .o_idx    (w_sel_idx),
        .o_any    (w_any_rdy)
    );

    assign iss_ready = w_any_free;
    assign iss_tag   = TAG_W'(TAG_BASE) + TAG_W'(w_alloc_idx);
    assign w_iss     = iss_valid && w_any_free;
    assign fu_valid  = w_any_rdy;
    assign w_disp    = w_any_rdy && fu_ready;
    assign busy_cnt  = r_busy_cnt;

    // Operands already on the CDB at issue are captured now; the producer will not broadcast again.
    always_comb begin
        w_new.busy = 1'b1;
        w_new.op   = iss_op;
        w_new.vj   = iss_vj;
        w_new.qj   = iss_qj;
        w_new.vk   = iss_vk;
        w_new.qk   = iss_qk;
        if (w_cdb_live && (iss_qj == cdb_tag)) begin
            w_new.vj = cdb_data;
            w_new.qj = TAG_NONE;
        end
        if (w_cdb_live && (iss_qk == cdb_tag)) begin
            w_new.vk = cdb_data;
            w_new.qk = TAG_NONE;
        end
    end

    always_comb begin
        fu_op  = '0;
        fu_a   = '0;
        fu_b   = '0;
        fu_tag = '0;
        if (w_any_rdy) begin
            fu_op  = r_ent[w_sel_idx].op;
            fu_a   = r_ent[w_sel_idx].vj;
            fu_b   = r_ent[w_sel_idx].vk;
            fu_tag = TAG_W'(TAG_BASE) + TAG_W'(w_sel_idx);
`ifdef RS_FWD_EN
            if (w_mj[w_sel_idx]) fu_a = cdb_data;
            if (w_mk[w_sel_idx]) fu_b = cdb_data;
`endif
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_busy_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_disp && w_sel_oh[i]) begin
                    r_ent[i].busy <= 1'b0;
                end else if (w_iss && w_alloc_oh[i]) begin
                    r_ent[i] <= w_new;
                end else if (r_ent[i].busy) begin
                    if (w_mj[i]) begin
                        r_ent[i].vj <= cdb_data;
                        r_ent[i].qj <= TAG_NONE;
                    end
                    if (w_mk[i]) begin
                        r_ent[i].vk <= cdb_data;
                        r_ent[i].qk <= TAG_NONE;
                    end
                end
            end
            case ({w_iss, w_disp})
                2'b10:   r_busy_cnt <= r_busy_cnt + CNT_W'(1);
                2'b01:   r_busy_cnt <= r_busy_cnt - CNT_W'(1);
                default: r_busy_cnt <= r_busy_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_tomasulo_rs.sv
// Scoreboard bench for tomasulo_rs: expected dispatches queued at stimulus, checked at FU handshake.
module tb_tomasulo_rs;

    logic        clk1;
    logic        rst;
    logic        iss_valid;
    logic        iss_ready;
    logic [2:0]  iss_op;
    logic [15:0] iss_vj;
    logic [3:0]  iss_qj;
    logic [15:0] iss_vk;
    logic [3:0]  iss_qk;
    logic [3:0]  iss_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        fu_valid;
    logic        fu_ready;
    logic [2:0]  fu_op;
    logic [15:0] fu_a;
    logic [15:0] fu_b;
    logic [3:0]  fu_tag;
    logic [2:0]  busy_cnt;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    tomasulo_rs #(.DEPTH(4), .DATA_W(16), .TAG_W(4), .OP_W(3), .TAG_BASE(1)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_op    (iss_op),
        .iss_vj    (iss_vj),
        .iss_qj    (iss_qj),
        .iss_vk    (iss_vk),
        .iss_qk    (iss_qk),
        .iss_tag   (iss_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .fu_valid  (fu_valid),
        .fu_ready  (fu_ready),
        .fu_op     (fu_op),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_tag    (fu_tag),
        .busy_cnt  (busy_cnt)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic samp();
        @(negedge clk1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] vj, input logic [3:0] qj,
                         input logic [15:0] vk, input logic [3:0] qk);
        iss_valid = 1'b1;
        iss_op    = op;
        iss_vj    = vj;
        iss_qj    = qj;
        iss_vk    = vk;
        iss_qk    = qk;
    endtask

    task automatic push(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain(input int n);
        fu_ready = 1'b1;
        repeat (n) step();
        fu_ready = 1'b0;
    endtask

    // Dispatch monitor: every FU handshake must match the oldest queued expectation.
    always @(negedge clk1) begin
        if (!rst && fu_valid && fu_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_dispatch_tag", 32'(fu_tag), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("disp_op",  32'(fu_op),  32'(e.op));
                check("disp_a",   32'(fu_a),   32'(e.a));
                check("disp_b",   32'(fu_b),   32'(e.b));
                check("disp_tag", 32'(fu_tag), 32'(e.tag));
            end
        end
    end

    initial begin
        rst = 1'b1; iss_valid = 1'b0; iss_op = '0; iss_vj = '0; iss_qj = '0;
        iss_vk = '0; iss_qk = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        fu_ready = 1'b0;
        #2;
        check("rst_fu_valid",  32'(fu_valid),  0);
        check("rst_fu_op",     32'(fu_op),     0);
        check("rst_fu_a",      32'(fu_a),      0);
        check("rst_fu_b",      32'(fu_b),      0);
        check("rst_fu_tag",    32'(fu_tag),    0);
        check("rst_busy_cnt",  32'(busy_cnt),  0);
        check("rst_iss_ready", 32'(iss_ready), 1);
        check("rst_iss_tag",   32'(iss_tag),   1);
        step();
        rst = 1'b0;
        step();

        // Ready-at-issue instruction dispatches the next cycle.
        issue(3'd1, 16'd5, 4'd0, 16'd7, 4'd0);
        samp();
        check("t1_iss_tag", 32'(iss_tag), 1);
        step();
        iss_valid = 1'b0;
        push(3'd1, 16'd5, 16'd7, 4'd1);
        fu_ready = 1'b1;
        samp();
        check("t1_fu_valid", 32'(fu_valid), 1);
        check("t1_busy1",    32'(busy_cnt), 1);
        step();
        fu_ready = 1'b0;
        samp();
        check("t1_busy0",     32'(busy_cnt), 0);
        check("t1_fu_valid0", 32'(fu_valid), 0);

        // Wakeup from CDB two cycles after issue.
        step();
        issue(3'd2, 16'hDEAD, 4'd3, 16'd2, 4'd0);
        step();
        iss_valid = 1'b0;
        samp();
        check("t2_wait_valid", 32'(fu_valid), 0);
        step();
        step();
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 16'h000A;
        samp();
`ifdef RS_FWD_EN
        check("t2_fwd_valid", 32'(fu_valid), 1);
        check("t2_fwd_a",     32'(fu_a),     32'h000A);
`else
        check("t2_bcast_valid", 32'(fu_valid), 0);
`endif
        step();
        cdb_valid = 1'b0;
        push(3'd2, 16'h000A, 16'd2, 4'd1);
        fu_ready = 1'b1;
        samp();
        check("t2_after_valid", 32'(fu_valid), 1);
        step();
        fu_ready = 1'b0;

        // Operand broadcast in the very issue cycle must not be lost.
        issue(3'd3, 16'h0000, 4'd2, 16'd4, 4'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 16'd9;
        step();
        iss_valid = 1'b0;
        cdb_valid = 1'b0;
        push(3'd3, 16'd9, 16'd4, 4'd1);
        fu_ready = 1'b1;
        samp();
        check("t3_valid", 32'(fu_valid), 1);
        step();
        fu_ready = 1'b0;
        samp();
        check("t3_busy0", 32'(busy_cnt), 0);

        // Fill all entries waiting on tag 6; extra issue dropped; wakeup dispatches in index order.
        for (int i = 0; i < 4; i++) begin
            step();
            issue(3'(i + 2), 16'h0, 4'd6, 16'(16'h100 + i), 4'd0);
            samp();
            check("t4_fill_tag", 32'(iss_tag), i + 1);
        end
        step();
        issue(3'd7, 16'd99, 4'd0, 16'd99, 4'd0);
        samp();
        check("t4_full_ready", 32'(iss_ready), 0);
        check("t4_full_busy",  32'(busy_cnt),  4);
        check("t4_full_valid", 32'(fu_valid),  0);
        step();
        iss_valid = 1'b0;
        samp();
        check("t4_drop_busy", 32'(busy_cnt), 4);
        step();
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 16'h0033;
        step();
        cdb_valid = 1'b0;
        for (int i = 0; i < 4; i++) push(3'(i + 2), 16'h0033, 16'(16'h100 + i), 4'(i + 1));
        drain(4);
        samp();
        check("t4_drained", 32'(busy_cnt), 0);

        // Full station: issue refused during dispatch, accepted next cycle into freed slot.
        for (int i = 0; i < 4; i++) begin
            step();
            issue(3'd4, 16'(16'h20 + i), 4'd0, 16'h1, 4'd0);
        end
        step();
        iss_valid = 1'b0;
        samp();
        check("t5_full_busy", 32'(busy_cnt), 4);
        step();
        issue(3'd5, 16'h0055, 4'd0, 16'h0066, 4'd0);
        fu_ready = 1'b1;
        push(3'd4, 16'h20, 16'h1, 4'd1);
        samp();
        check("t5_refused", 32'(iss_ready), 0);
        step();
        fu_ready = 1'b0;
        samp();
        check("t5_ready_again", 32'(iss_ready), 1);
        check("t5_freed_tag",   32'(iss_tag),   1);
        step();
        iss_valid = 1'b0;
        samp();
        check("t5_busy_refill", 32'(busy_cnt), 4);
        step();
        push(3'd5, 16'h0055, 16'h0066, 4'd1);
        for (int i = 1; i < 4; i++) push(3'd4, 16'(16'h20 + i), 16'h1, 4'(i + 1));
        drain(4);
        samp();
        check("t5_drained", 32'(busy_cnt), 0);

        // Asynchronous reset with three ready entries pending.
        for (int i = 0; i < 3; i++) begin
            step();
            issue(3'd6, 16'h7, 4'd0, 16'h8, 4'd0);
        end
        step();
        iss_valid = 1'b0;
        samp();
        check("t6_pre_valid", 32'(fu_valid), 1);
        check("t6_pre_busy",  32'(busy_cnt), 3);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(fu_valid),  0);
        check("t6_rst_busy",  32'(busy_cnt),  0);
        check("t6_rst_tag",   32'(iss_tag),   1);
        check("t6_rst_ready", 32'(iss_ready), 1);
        step();
        rst = 1'b0;
        step();
        issue(3'd1, 16'h11, 4'd0, 16'h22, 4'd0);
        step();
        iss_valid = 1'b0;
        push(3'd1, 16'h11, 16'h22, 4'd1);
        drain(1);
        samp();
        check("t6_post_busy", 32'(busy_cnt), 0);

        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
